// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the PC, forms sequential/branch/jump/register targets,
// picks the next PC by fixed priority and keeps a circular return-address stack.
module pc_next_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      INDEX_W   = 26,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [15:0]        branch_imm_i,
    input  logic               jump_i,
    input  logic               link_i,
    input  logic               jr_i,
    input  logic               ret_i,
    input  logic [INDEX_W-1:0] instr_index_i,
    input  logic [WIDTH-1:0]   jr_target_i,
    output logic [WIDTH-1:0]   pc_o,
    output logic [WIDTH-1:0]   pc_plus4_o,
    output logic               ras_empty_o,
    output logic               ras_full_o
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    // Keeps the PC bits above the instruction-index field for jump targets.
    localparam logic [WIDTH-1:0] JmpMask = {WIDTH{1'b1}} << (INDEX_W + 2);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PtrW-1:0]  tp_q, tp_d, tp_inc;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] jmp_tgt;
    logic [WIDTH-1:0] rt_tgt;
    logic             ras_empty;
    logic             ras_full;
    logic             push;
    logic             pop;

    assign pc_plus4  = pc_q + WIDTH'(4);
    assign imm_ext   = WIDTH'($signed(branch_imm_i));
    assign br_tgt    = pc_plus4 + (imm_ext << 2);
    assign jmp_tgt   = (pc_plus4 & JmpMask) | (WIDTH'(instr_index_i) << 2);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));
    assign rt_tgt    = ras_empty ? jr_target_i : ras_q[tp_q];
    assign tp_inc    = tp_q + PtrW'(1);

    // ret outranks jr and jump, so a JAL is only pushed when neither is present.
    assign push = jump_i && link_i && !ret_i && !jr_i;
    assign pop  = ret_i && !ras_empty;

    always_comb begin
        pc_d  = pc_plus4;
        tp_d  = tp_q;
        cnt_d = cnt_q;
        if (ret_i) begin
            pc_d = rt_tgt;
        end else if (jr_i) begin
            pc_d = jr_target_i;
        end else if (jump_i) begin
            pc_d = jmp_tgt;
        end else if (branch_taken_i) begin
            pc_d = br_tgt;
        end
        if (push) begin
            tp_d = tp_inc;
            if (!ras_full) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop) begin
            tp_d  = tp_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q  <= RESET_PC;
            tp_q  <= '0;
            cnt_q <= '0;
        end else if (!stall_i) begin
            pc_q  <= pc_d;
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack contents need no reset; count alone decides validity.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !stall_i && push) begin
            ras_q[tp_inc] <= pc_plus4;
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4;
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;

endmodule
